// File: rtl/axi_outstanding_limit.sv
// AXI4 pass-through that caps outstanding write/read bursts and holds W until its AW is accepted.
// Zero latency (pure combinational gating); AW/AR/W backpressured while full / no pending AW, B/R ungated.
module axi_outstanding_limit #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 8,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int BUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int RUSER_WIDTH        = 1,
  parameter int MAX_WR_OUTSTANDING = 16,
  parameter int MAX_RD_OUTSTANDING = 16,
  localparam int CW_WR             = $clog2(MAX_WR_OUTSTANDING + 1),
  localparam int CW_RD             = $clog2(MAX_RD_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,

  output logic [CW_WR-1:0]        wr_outstanding,
  output logic [CW_RD-1:0]        rd_outstanding,
  output logic                    status_err
);

  localparam logic [CW_WR-1:0] WR_MAX = CW_WR'(MAX_WR_OUTSTANDING);
  localparam logic [CW_RD-1:0] RD_MAX = CW_RD'(MAX_RD_OUTSTANDING);

  logic [CW_WR-1:0] wr_cnt;
  logic [CW_RD-1:0] rd_cnt;
  logic [CW_WR-1:0] pend_w;
  logic             wr_full, rd_full, w_ok;
  logic             aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  assign wr_full = (wr_cnt == WR_MAX);
  assign rd_full = (rd_cnt == RD_MAX);
  assign w_ok    = (pend_w != '0);

  assign m_axi_awvalid = s_axi_awvalid & ~wr_full & ~rst;
  assign s_axi_awready = m_axi_awready & ~wr_full & ~rst;
  assign m_axi_arvalid = s_axi_arvalid & ~rd_full & ~rst;
  assign s_axi_arready = m_axi_arready & ~rd_full & ~rst;
  assign m_axi_wvalid  = s_axi_wvalid & w_ok & ~rst;
  assign s_axi_wready  = m_axi_wready & w_ok & ~rst;

  assign m_axi_awid     = s_axi_awid;
  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awsize   = s_axi_awsize;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awregion = s_axi_awregion;
  assign m_axi_awuser   = s_axi_awuser;
  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;
  assign m_axi_wuser    = s_axi_wuser;
  assign m_axi_arid     = s_axi_arid;
  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arsize   = s_axi_arsize;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;
  assign m_axi_aruser   = s_axi_aruser;

  // Response channels are never gated, even in reset.
  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_buser  = m_axi_buser;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_ruser  = m_axi_ruser;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_last_hs = s_axi_wvalid & s_axi_wready & s_axi_wlast;
  assign b_hs      = m_axi_bvalid & s_axi_bready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign r_last_hs = m_axi_rvalid & s_axi_rready & m_axi_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      pend_w     <= '0;
      status_err <= 1'b0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt <= wr_cnt + CW_WR'(1);
        2'b01:   if (wr_cnt != '0) wr_cnt <= wr_cnt - CW_WR'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      case ({ar_hs, r_last_hs})
        2'b10:   rd_cnt <= rd_cnt + CW_RD'(1);
        2'b01:   if (rd_cnt != '0) rd_cnt <= rd_cnt - CW_RD'(1);
        default: rd_cnt <= rd_cnt;
      endcase
      // Spurious B responses can leave pend_w above wr_cnt; saturate rather than wrap.
      case ({aw_hs, w_last_hs})
        2'b10:   if (pend_w != '1) pend_w <= pend_w + CW_WR'(1);
        2'b01:   pend_w <= pend_w - CW_WR'(1);
        default: pend_w <= pend_w;
      endcase
      status_err <= (b_hs & (wr_cnt == '0)) | (r_last_hs & (rd_cnt == '0));
    end
  end

  assign wr_outstanding = wr_cnt;
  assign rd_outstanding = rd_cnt;

endmodule

// File: tb/tb_axi_outstanding_limit.sv
// Directed bench for axi_outstanding_limit (MAX_WR=4, MAX_RD=2) plus a short random soak against a count model.
module tb_axi_outstanding_limit;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_arid, s_axi_arlen;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata;
  logic [2:0]  s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst;
  logic        s_axi_awlock, s_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_awregion, s_axi_wstrb;
  logic [3:0]  s_axi_arcache, s_axi_arqos, s_axi_arregion;
  logic [0:0]  s_axi_awuser, s_axi_wuser, s_axi_aruser, s_axi_buser, s_axi_ruser;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [7:0]  s_axi_bid, s_axi_rid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_wstrb;
  logic [3:0]  m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic [0:0]  m_axi_awuser, m_axi_wuser, m_axi_aruser, m_axi_buser, m_axi_ruser;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid, m_axi_rid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  logic [2:0]  wr_outstanding;
  logic [1:0]  rd_outstanding;
  logic        status_err;

  int n_chk;
  int n_err;
  int mwr, mrd, mpend, mdone;
  bit aw_h, wl_h, b_h, ar_h, r_h;

  axi_outstanding_limit #(
    .MAX_WR_OUTSTANDING(4),
    .MAX_RD_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .status_err(status_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_rready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rlast = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    clr();
    s_axi_awid = 8'h5A; s_axi_awaddr = 32'h1000_0040; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd1; s_axi_awlock = 0; s_axi_awcache = 4'h3; s_axi_awprot = 3'd0;
    s_axi_awqos = 4'h0; s_axi_awregion = 4'h0; s_axi_awuser = 1'b1;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_wuser = 1'b0;
    s_axi_arid = 8'h33; s_axi_araddr = 32'h2000_0000; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arlock = 0; s_axi_arcache = 4'h3; s_axi_arprot = 3'd0;
    s_axi_arqos = 4'h0; s_axi_arregion = 4'h0; s_axi_aruser = 1'b0;
    m_axi_bid = 8'h5A; m_axi_bresp = 2'b00; m_axi_buser = 1'b0;
    m_axi_rid = 8'h33; m_axi_rdata = 32'hCAFE_F00D; m_axi_rresp = 2'b00; m_axi_ruser = 1'b0;

    // Reset: gated handshakes low, B passes through.
    rst = 1;
    s_axi_awvalid = 1; m_axi_awready = 1; m_axi_bvalid = 1;
    settle();
    chk("rst_m_awvalid", m_axi_awvalid, 0);
    chk("rst_s_awready", s_axi_awready, 0);
    chk("rst_b_pass", s_axi_bvalid, 1);
    tick(); tick();
    clr(); rst = 0;
    settle();
    chk("rst_wr_cnt", wr_outstanding, 0);
    chk("rst_rd_cnt", rd_outstanding, 0);
    chk("rst_err", status_err, 0);

    // Single AW(len=3) + 4 W beats; W waits for the AW handshake.
    s_axi_awvalid = 1; m_axi_awready = 1; s_axi_wvalid = 1; m_axi_wready = 1;
    settle();
    chk("t1_w_held", m_axi_wvalid, 0);
    chk("t1_wready_held", s_axi_wready, 0);
    chk("t1_aw_pass", m_axi_awvalid, 1);
    chk("t1_awaddr", m_axi_awaddr, 32'h1000_0040);
    tick();
    s_axi_awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      s_axi_wdata = 32'hA000 + b; s_axi_wlast = (b == 3);
      settle();
      chk("t1_wvalid", m_axi_wvalid, 1);
      chk("t1_wdata", m_axi_wdata, 32'hA000 + b);
      chk("t1_wr_cnt", wr_outstanding, 1);
      tick();
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    m_axi_bvalid = 1; s_axi_bready = 1;
    settle();
    chk("t1_b_pass", s_axi_bvalid, 1);
    chk("t1_bid", s_axi_bid, 8'h5A);
    tick();
    m_axi_bvalid = 0; s_axi_bready = 0;
    settle();
    chk("t1_wr_cnt_done", wr_outstanding, 0);
    chk("t1_err", status_err, 0);

    // W presented 3 cycles before its AW.
    s_axi_wvalid = 1; s_axi_wdata = 32'hB000;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t3_w_early", m_axi_wvalid, 0);
      tick();
    end
    s_axi_awvalid = 1; s_axi_awlen = 8'd1;
    settle();
    chk("t3_w_aw_cycle", m_axi_wvalid, 0);
    tick();
    s_axi_awvalid = 0;
    for (int b = 0; b < 2; b++) begin
      s_axi_wdata = 32'hB000 + b; s_axi_wlast = (b == 1);
      settle();
      chk("t3_wvalid", m_axi_wvalid, 1);
      chk("t3_wdata", m_axi_wdata, 32'hB000 + b);
      tick();
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    settle();
    chk("t3_w_after", m_axi_wvalid, 0);
    m_axi_bvalid = 1; s_axi_bready = 1;
    tick();
    m_axi_bvalid = 0; s_axi_bready = 0;
    settle();
    chk("t3_wr_cnt", wr_outstanding, 0);

    // Six back-to-back AWs with MAX_WR=4 and B held.
    s_axi_awvalid = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t2_awready", s_axi_awready, (i < 4));
      chk("t2_m_awvalid", m_axi_awvalid, (i < 4));
      tick();
    end
    settle();
    chk("t2_wr_full", wr_outstanding, 4);
    m_axi_bvalid = 1; s_axi_bready = 1;
    settle();
    chk("t2_no_bypass", s_axi_awready, 0);
    tick();
    m_axi_bvalid = 0; s_axi_bready = 0;
    settle();
    chk("t2_wr_freed", wr_outstanding, 3);
    chk("t2_awready_freed", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 0;
    settle();
    chk("t2_wr_refull", wr_outstanding, 4);
    m_axi_bvalid = 1; s_axi_bready = 1;
    tick();
    m_axi_bvalid = 0; s_axi_bready = 0;
    settle();
    chk("t2_wr_three", wr_outstanding, 3);

    // Reads with MAX_RD=2; final R of #1 coincides with AR #3.
    s_axi_arvalid = 1; m_axi_arready = 1;
    settle();
    chk("t4_ar1", s_axi_arready, 1);
    chk("t4_araddr", m_axi_araddr, 32'h2000_0000);
    tick();
    settle();
    chk("t4_ar2", s_axi_arready, 1);
    tick();
    m_axi_rvalid = 1; m_axi_rlast = 1; s_axi_rready = 1;
    settle();
    chk("t4_ar3_rej", s_axi_arready, 0);
    chk("t4_rd_full", rd_outstanding, 2);
    chk("t4_r_pass", s_axi_rvalid, 1);
    chk("t4_rdata", s_axi_rdata, 32'hCAFE_F00D);
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0; s_axi_rready = 0;
    settle();
    chk("t4_rd_freed", rd_outstanding, 1);
    chk("t4_ar3_acc", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 0;
    settle();
    chk("t4_rd_two", rd_outstanding, 2);
    m_axi_rvalid = 1; s_axi_rready = 1;
    tick();
    settle();
    chk("t4_rd_nonlast", rd_outstanding, 2);
    m_axi_rlast = 1;
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0; s_axi_rready = 0;
    settle();
    chk("t5_rd_one", rd_outstanding, 1);

    // AR handshake and R-last in the same cycle.
    s_axi_arvalid = 1; m_axi_rvalid = 1; m_axi_rlast = 1; s_axi_rready = 1;
    tick();
    clr();
    settle();
    chk("t5_rd_same", rd_outstanding, 1);
    chk("t5_no_err", status_err, 0);

    // Reset with 3 writes outstanding.
    rst = 1;
    s_axi_awvalid = 1; m_axi_awready = 1; s_axi_wvalid = 1; m_axi_wready = 1;
    s_axi_arvalid = 1; m_axi_arready = 1; m_axi_rvalid = 1;
    settle();
    chk("t6_pre_wr", wr_outstanding, 3);
    chk("t6_m_awvalid", m_axi_awvalid, 0);
    chk("t6_s_wready", s_axi_wready, 0);
    chk("t6_m_wvalid", m_axi_wvalid, 0);
    chk("t6_s_arready", s_axi_arready, 0);
    chk("t6_r_pass", s_axi_rvalid, 1);
    tick();
    clr(); rst = 0;
    settle();
    chk("t6_wr_zero", wr_outstanding, 0);
    chk("t6_rd_zero", rd_outstanding, 0);
    s_axi_wvalid = 1; m_axi_wready = 1;
    settle();
    chk("t6_pend_cleared", m_axi_wvalid, 0);
    clr();

    // Unsolicited B and R-last.
    m_axi_bvalid = 1; s_axi_bready = 1;
    settle();
    chk("t5_b_pass", s_axi_bvalid, 1);
    chk("t5_err_pre", status_err, 0);
    tick();
    clr();
    settle();
    chk("t5_b_err", status_err, 1);
    chk("t5_b_cnt", wr_outstanding, 0);
    tick();
    chk("t5_err_clear", status_err, 0);
    m_axi_rvalid = 1; m_axi_rlast = 1; s_axi_rready = 1;
    tick();
    clr();
    settle();
    chk("t5_r_err", status_err, 1);
    chk("t5_r_cnt", rd_outstanding, 0);
    tick();

    // Random soak against a count model of the downstream port.
    mwr = 0; mrd = 0; mpend = 0; mdone = 0;
    for (int c = 0; c < 300; c++) begin
      s_axi_awvalid = 1'($urandom_range(0, 1));
      m_axi_awready = 1'($urandom_range(0, 1));
      s_axi_wvalid  = 1'($urandom_range(0, 1));
      s_axi_wlast   = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
      s_axi_arvalid = 1'($urandom_range(0, 1));
      m_axi_arready = 1'($urandom_range(0, 1));
      m_axi_bvalid  = (mdone > 0) && ($urandom_range(0, 1) == 1);
      s_axi_bready  = 1'($urandom_range(0, 1));
      m_axi_rvalid  = (mrd > 0) && ($urandom_range(0, 1) == 1);
      m_axi_rlast   = 1'($urandom_range(0, 1));
      s_axi_rready  = 1'($urandom_range(0, 1));
      settle();
      chk("soak_awready", s_axi_awready, m_axi_awready && (mwr != 4));
      chk("soak_wready", s_axi_wready, m_axi_wready && (mpend != 0));
      chk("soak_arready", s_axi_arready, m_axi_arready && (mrd != 2));
      aw_h = s_axi_awvalid && m_axi_awready && (mwr != 4);
      wl_h = s_axi_wvalid && m_axi_wready && (mpend != 0) && s_axi_wlast;
      b_h  = m_axi_bvalid && s_axi_bready;
      ar_h = s_axi_arvalid && m_axi_arready && (mrd != 2);
      r_h  = m_axi_rvalid && s_axi_rready && m_axi_rlast;
      mwr   = mwr + int'(aw_h) - int'(b_h);
      mpend = mpend + int'(aw_h) - int'(wl_h);
      mdone = mdone + int'(wl_h) - int'(b_h);
      mrd   = mrd + int'(ar_h) - int'(r_h);
      tick();
      chk("soak_wr_cnt", wr_outstanding, mwr);
      chk("soak_rd_cnt", rd_outstanding, mrd);
      chk("soak_err", status_err, 0);
    end
    clr();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
